// File: rtl/snake_body_tracker_if.sv
// Snake body tracker bundle: game-control inputs, playfield bounds and the
// position/status outputs consumed by the apple placement logic.
//   master : drives clear/start/move_tick/direction/good_collision/bounds
//   slave  : the tracker; drives head, segment arrays, length and flags
interface snake_body_tracker_if #(
  parameter int MAX_LENGTH = 30
);
  logic                       clear;
  logic                       start;
  logic                       move_tick;
  logic [1:0]                 direction;
  logic                       good_collision;
  logic [3:0]                 xmax;
  logic [3:0]                 xmin;
  logic [3:0]                 ymax;
  logic [3:0]                 ymin;
  logic [3:0]                 snake_head_x;
  logic [3:0]                 snake_head_y;
  logic [MAX_LENGTH-1:0][3:0] snakeArrayX;
  logic [MAX_LENGTH-1:0][3:0] snakeArrayY;
  logic [4:0]                 length;
  logic [1:0]                 cur_dir;
  logic                       running;
  logic                       dead;
  logic                       wall_hit;
  logic                       self_hit;
  logic                       max_reached;

  modport master (
    output clear, start, move_tick, direction, good_collision,
           xmax, xmin, ymax, ymin,
    input  snake_head_x, snake_head_y, snakeArrayX, snakeArrayY,
           length, cur_dir, running, dead, wall_hit, self_hit, max_reached
  );

  modport slave (
    input  clear, start, move_tick, direction, good_collision,
           xmax, xmin, ymax, ymin,
    output snake_head_x, snake_head_y, snakeArrayX, snakeArrayY,
           length, cur_dir, running, dead, wall_hit, self_hit, max_reached
  );
endinterface

// File: rtl/snake_body_tracker.sv
// Snake body tracker: owns head position, ordered segment arrays, length and
// travel direction. Steps one cell per move_tick while running, grows on
// good_collision, and detects wall and self collisions.
// Ports:
//   system_clk : clock, all state changes on its rising edge
//   nreset     : synchronous active-low reset
//   bus        : snake_body_tracker_if.slave (controls, bounds, state outputs)
//
// state | meaning
// IDLE  | reset position shown, waiting for start; ticks ignored
// RUN   | stepping on move_tick, growth accepted
// DEAD  | collision happened; everything frozen until clear/reset
module snake_body_tracker #(
  parameter int         MAX_LENGTH  = 30,
  parameter int         INIT_LENGTH = 3,
  parameter logic [3:0] START_X     = 4'd4,
  parameter logic [3:0] START_Y     = 4'd4
) (
  input logic                 system_clk,
  input logic                 nreset,
  snake_body_tracker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  typedef logic [MAX_LENGTH-1:0][3:0] seg_arr_t;

  state_t     r_state, w_state_nxt;
  seg_arr_t   r_seg_x, r_seg_y, w_seg_x_nxt, w_seg_y_nxt;
  seg_arr_t   w_shift_x, w_shift_y, w_step_x, w_step_y;
  seg_arr_t   w_init_x, w_init_y;
  logic [4:0] r_len, w_len_nxt, w_new_len, w_chk_len;
  logic [1:0] r_dir, w_dir_nxt, w_dir_use, w_opp;
  logic       r_wall, w_wall_nxt;
  logic       r_self, w_self_nxt;
  logic       r_max, w_max_nxt;
  logic       r_grow_pend, w_grow_pend_nxt;
  logic       w_step, w_grow, w_room, w_grow_acc;
  logic [3:0] w_next_x, w_next_y, w_tail_x, w_tail_y;
  logic       w_edge, w_wall, w_self;

  // Segments beyond INIT_LENGTH-1 repeat the initial tail.
  function automatic seg_arr_t f_init_x();
    int k;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      k = (i < INIT_LENGTH) ? i : INIT_LENGTH - 1;
      f_init_x[i] = START_X - 4'(k);
    end
  endfunction

  function automatic seg_arr_t f_init_y();
    for (int i = 0; i < MAX_LENGTH; i++) f_init_y[i] = START_Y;
  endfunction

  assign w_init_x = f_init_x();
  assign w_init_y = f_init_y();

  assign w_step     = bus.move_tick && (r_state == S_RUN);
  assign w_opp      = {r_dir[1], ~r_dir[0]};
  assign w_dir_use  = (bus.direction == w_opp) ? r_dir : bus.direction;
  assign w_grow     = r_grow_pend | bus.good_collision;
  assign w_room     = r_len < 5'(MAX_LENGTH);
  assign w_grow_acc = w_grow & w_room;
  // An accepted grow keeps the tail in place, so it becomes a hittable cell.
  assign w_chk_len  = w_grow_acc ? r_len : r_len - 5'd1;
  assign w_new_len  = r_len + {4'd0, w_grow_acc};

  always_comb begin
    w_next_x = r_seg_x[0];
    w_next_y = r_seg_y[0];
    w_edge   = 1'b0;
    case (w_dir_use)
      2'd0: begin
        w_next_y = r_seg_y[0] - 4'd1;
        w_edge   = (r_seg_y[0] == 4'd0);
      end
      2'd1: w_next_y = r_seg_y[0] + 4'd1;
      2'd2: begin
        w_next_x = r_seg_x[0] - 4'd1;
        w_edge   = (r_seg_x[0] == 4'd0);
      end
      default: w_next_x = r_seg_x[0] + 4'd1;
    endcase
    w_wall = w_edge || (w_next_x < bus.xmin) || (w_next_x > bus.xmax) ||
             (w_next_y < bus.ymin) || (w_next_y > bus.ymax);
  end

  always_comb begin
    w_self = 1'b0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if ((5'(i) < w_chk_len) && (r_seg_x[i] == w_next_x) &&
          (r_seg_y[i] == w_next_y))
        w_self = 1'b1;
    end
  end

  // Shift toward the tail; a grown snake keeps the old tail at index len.
  always_comb begin
    w_shift_x    = r_seg_x;
    w_shift_y    = r_seg_y;
    w_shift_x[0] = w_next_x;
    w_shift_y[0] = w_next_y;
    for (int i = 1; i < MAX_LENGTH; i++) begin
      w_shift_x[i] = r_seg_x[i-1];
      w_shift_y[i] = r_seg_y[i-1];
    end
  end

  // Inactive slots mirror the new tail so full-array scans see no ghosts.
  always_comb begin
    w_tail_x = w_shift_x[w_new_len - 5'd1];
    w_tail_y = w_shift_y[w_new_len - 5'd1];
    w_step_x = w_shift_x;
    w_step_y = w_shift_y;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (5'(i) >= w_new_len) begin
        w_step_x[i] = w_tail_x;
        w_step_y[i] = w_tail_y;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_seg_x_nxt     = r_seg_x;
    w_seg_y_nxt     = r_seg_y;
    w_len_nxt       = r_len;
    w_dir_nxt       = r_dir;
    w_wall_nxt      = r_wall;
    w_self_nxt      = r_self;
    w_max_nxt       = r_max;
    w_grow_pend_nxt = r_grow_pend;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_step) begin
          w_dir_nxt       = w_dir_use;
          w_grow_pend_nxt = 1'b0;
          if (w_wall || w_self) begin
            w_state_nxt = S_DEAD;
            w_wall_nxt  = r_wall | w_wall;
            w_self_nxt  = r_self | w_self;
          end else begin
            w_seg_x_nxt = w_step_x;
            w_seg_y_nxt = w_step_y;
            w_len_nxt   = w_new_len;
            if (w_grow && !w_room) w_max_nxt = 1'b1;
          end
        end else if (bus.good_collision) begin
          w_grow_pend_nxt = 1'b1;
        end
      end
      S_DEAD: ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (!nreset || bus.clear) begin
      r_state     <= S_IDLE;
      r_seg_x     <= w_init_x;
      r_seg_y     <= w_init_y;
      r_len       <= 5'(INIT_LENGTH);
      r_dir       <= 2'd3;
      r_wall      <= 1'b0;
      r_self      <= 1'b0;
      r_max       <= 1'b0;
      r_grow_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_seg_x     <= w_seg_x_nxt;
      r_seg_y     <= w_seg_y_nxt;
      r_len       <= w_len_nxt;
      r_dir       <= w_dir_nxt;
      r_wall      <= w_wall_nxt;
      r_self      <= w_self_nxt;
      r_max       <= w_max_nxt;
      r_grow_pend <= w_grow_pend_nxt;
    end
  end

  assign bus.snake_head_x = r_seg_x[0];
  assign bus.snake_head_y = r_seg_y[0];
  assign bus.snakeArrayX  = r_seg_x;
  assign bus.snakeArrayY  = r_seg_y;
  assign bus.length       = r_len;
  assign bus.cur_dir      = r_dir;
  assign bus.running      = (r_state == S_RUN);
  assign bus.dead         = (r_state == S_DEAD);
  assign bus.wall_hit     = r_wall;
  assign bus.self_hit     = r_self;
  assign bus.max_reached  = r_max;

endmodule
